// File: rtl/pla_ibm_arbiter.sv
// Round-robin issue controller sharing one pla__ibm decode array between NREQ
// requesters; results return in order through a 2-entry response buffer.
module pla_ibm_arbiter #(
  parameter int NREQ = 4,
  parameter int XW   = 48,
  parameter int ZW   = 17,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*XW-1:0] req_x,
  output logic [NREQ-1:0]    req_ready,
  output logic [XW-1:0]      pla_x,
  input  logic [ZW-1:0]      pla_z,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ZW-1:0]      rsp_z,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic           credit;
  logic           hs;
  logic           pop;
  logic [2:0]     occ;

  logic           s1_valid;
  logic [IDW-1:0] s1_id;

  logic [1:0]     cnt;
  logic           rd_ptr;
  logic           wr_ptr;
  logic [ZW-1:0]  buf_z  [2];
  logic [IDW-1:0] buf_id [2];

  assign rsp_valid = (cnt != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_z     = buf_z[rd_ptr];
  assign rsp_id    = buf_id[rd_ptr];
  assign busy      = s1_valid | rsp_valid;

  // Occupancy after this cycle's pop; a free slot must exist for every issue.
  assign occ    = {1'b0, cnt} + {2'b00, s1_valid} - {2'b00, pop};
  assign credit = !rst && (occ < 3'd2);

  // Grant stage: first valid requester after ptr, wrapping.
  always_comb begin
    logic [IDW:0] cand;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[IDW-1:0];
      end
    end
  end

  assign req_ready = (credit && gnt_found) ? (NREQ'(1) << gnt_id) : '0;
  assign hs        = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= IDW'(NREQ - 1);
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      pla_x     <= '0;
      cnt       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      buf_z[0]  <= '0;
      buf_z[1]  <= '0;
      buf_id[0] <= '0;
      buf_id[1] <= '0;
    end else begin
      // Issue stage S1: the winner's vector is sampled only here.
      s1_valid <= hs;
      if (hs) begin
        ptr   <= gnt_id;
        s1_id <= gnt_id;
        pla_x <= req_x[gnt_id*XW +: XW];
      end
      // Capture stage: PLA result of the S1 vector lands in the buffer.
      if (s1_valid) begin
        buf_z[wr_ptr]  <= pla_z;
        buf_id[wr_ptr] <= s1_id;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, s1_valid} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_pla_ibm_arbiter.sv
// Randomized bench for pla_ibm_arbiter against a transaction-level queue model.
module tb_pla_ibm_arbiter;
  localparam int NREQ = 4;
  localparam int XW   = 48;
  localparam int ZW   = 17;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic [XW-1:0]      pla_x;
  logic [ZW-1:0]      pla_z;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ZW-1:0]      rsp_z;
  logic [IDW-1:0]     rsp_id;
  logic               busy;

  pla_ibm_arbiter #(.NREQ(NREQ), .XW(XW), .ZW(ZW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
    .req_ready(req_ready), .pla_x(pla_x), .pla_z(pla_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external decode array.
  function automatic logic [ZW-1:0] pla_ref(input logic [XW-1:0] x);
    logic [ZW-1:0] z;
    for (int k = 0; k < ZW; k++)
      z[k] = (x[k] & x[k+17]) | x[k+31];
    z[2] = x[14] & ~x[16] & x[18];
    return z;
  endfunction

  assign pla_z = pla_ref(pla_x);

  // Model: every issued-but-unpopped transaction, oldest first.
  typedef struct { int id; logic [ZW-1:0] z; int cyc; } ent_t;
  ent_t            mq[$];
  int              m_ptr = NREQ - 1;
  logic [XW-1:0]   m_x = '0;
  int              cyc = 0;

  logic            exp_grant;
  int              exp_gid;
  int              exp_pop;
  logic [NREQ-1:0] exp_ready;
  logic            exp_rsp_valid;
  logic [ZW-1:0]   exp_z;
  int              exp_id;
  logic            exp_busy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic eval();
    int idx;
    #1;
    exp_rsp_valid = 1'b0;
    exp_z = '0;
    exp_id = 0;
    if (mq.size() > 0) begin
      if (mq[0].cyc <= cyc - 2) begin
        exp_rsp_valid = 1'b1;
        exp_z  = mq[0].z;
        exp_id = mq[0].id;
      end
    end
    exp_pop   = (exp_rsp_valid && rsp_ready) ? 1 : 0;
    exp_grant = 1'b0;
    exp_gid   = 0;
    exp_ready = '0;
    if (!rst && (mq.size() - exp_pop) < 2) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!exp_grant && req_valid[idx[IDW-1:0]]) begin
          exp_grant = 1'b1;
          exp_gid   = idx;
        end
      end
    end
    if (exp_grant) exp_ready[exp_gid[IDW-1:0]] = 1'b1;
    exp_busy = (mq.size() > 0);
  endtask

  task automatic adv();
    logic [XW-1:0] xv;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ptr = NREQ - 1;
      m_x   = '0;
    end else begin
      if (exp_pop != 0) mq.delete(0);
      if (exp_grant) begin
        xv = req_x[exp_gid*XW +: XW];
        mq.push_back('{exp_gid, pla_ref(xv), cyc});
        m_ptr = exp_gid;
        m_x   = xv;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_x();
    for (int i = 0; i < NREQ; i++)
      req_x[i*XW +: XW] = XW'({$urandom, $urandom});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    eval();
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b1; rand_x();
    for (int i = 0; i < 2; i++) begin
      eval();
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      adv();
    end
    rst = 1'b0; req_valid = '0;
    eval();
    n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_busy: got %b want 00", {rsp_valid, busy}); end
    n_checks++; if (pla_x !== '0) begin n_fail++; $display("FAIL reset_pla_x: got %h want 0", pla_x); end
    n_checks++; if ({rsp_z, rsp_id} !== '0) begin n_fail++; $display("FAIL reset_rsp: got z=%h id=%0d want 0", rsp_z, rsp_id); end
    adv();
  endtask

  task automatic test_single();
    logic [XW-1:0] vec;
    vec = '0; vec[14] = 1'b1; vec[18] = 1'b1;
    req_x = '0; req_x[2*XW +: XW] = vec; req_valid = 4'b0100; rsp_ready = 1'b1;
    eval();
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    adv();
    req_valid = '0; req_x = '1;
    eval();
    n_checks++; if (pla_x !== 48'h0000_0004_4000) begin n_fail++; $display("FAIL single_pla_x: got %h want 000000044000", pla_x); end
    n_checks++; if ({rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL single_s1: got valid/busy %b want 01", {rsp_valid, busy}); end
    adv();
    eval();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp: got valid=%b id=%0d want 1/2", rsp_valid, rsp_id); end
    n_checks++; if ({rsp_z[8], rsp_z[2], rsp_z[0]} !== 3'b010) begin n_fail++; $display("FAIL single_z: got z08/z02/z00=%b want 010", {rsp_z[8], rsp_z[2], rsp_z[0]}); end
    adv();
    eval();
    n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_drain: got %b want 00", {rsp_valid, busy}); end
    adv();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] w;
    pulse_reset();
    req_valid = '1; rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_x();
      eval();
      w = NREQ'(1 << (i % NREQ));
      n_checks++; if (req_ready !== w) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", i, req_ready, w); end
      if (i >= 2) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'((i - 2) % NREQ) || rsp_z !== exp_z) begin
          n_fail++; $display("FAIL fair_rsp[%0d]: got v=%b id=%0d z=%h want 1/%0d/%h", i, rsp_valid, rsp_id, rsp_z, (i - 2) % NREQ, exp_z); end
      end else begin
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_early[%0d]: got rsp_valid=%b want 0", i, rsp_valid); end
      end
      adv();
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      eval();
      n_checks++; if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid && rsp_id !== IDW'(exp_id))) begin
        n_fail++; $display("FAIL fair_drain[%0d]: got v=%b id=%0d want %b/%0d", i, rsp_valid, rsp_id, exp_rsp_valid, exp_id); end
      adv();
    end
  endtask

  task automatic test_backpressure();
    int grants, nresp;
    logic [ZW-1:0] held_z;
    logic [IDW-1:0] held_id;
    pulse_reset();
    req_valid = '1; rsp_ready = 1'b0; grants = 0; held_z = '0; held_id = '0;
    for (int i = 0; i < 10; i++) begin
      rand_x();
      eval();
      grants += $countones(req_ready);
      n_checks++; if (req_ready !== exp_ready || rsp_valid !== exp_rsp_valid) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got ready=%b v=%b want %b/%b", i, req_ready, rsp_valid, exp_ready, exp_rsp_valid); end
      if (i == 2) begin
        held_z = rsp_z; held_id = rsp_id;
        n_checks++; if (rsp_id !== 2'd0 || rsp_z !== exp_z) begin n_fail++; $display("FAIL bp_head: got id=%0d z=%h want 0/%h", rsp_id, rsp_z, exp_z); end
      end else if (i > 2) begin
        n_checks++; if (rsp_id !== held_id || rsp_z !== held_z) begin n_fail++; $display("FAIL bp_stable[%0d]: got id=%0d z=%h want %0d/%h", i, rsp_id, rsp_z, held_id, held_z); end
      end
      adv();
    end
    n_checks++; if (grants !== 2) begin n_fail++; $display("FAIL bp_grants: got %0d want 2", grants); end
    rsp_ready = 1'b1; nresp = 0;
    for (int i = 0; i < 16; i++) begin
      rand_x();
      eval();
      if (i == 0) begin
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_grant: got %b want 0100", req_ready); end
      end
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, req_ready, exp_ready); end
      if (rsp_valid === 1'b1) begin
        n_checks++; if (rsp_id !== IDW'(nresp % NREQ) || rsp_z !== exp_z) begin
          n_fail++; $display("FAIL bp_order[%0d]: got id=%0d z=%h want %0d/%h", i, rsp_id, rsp_z, nresp % NREQ, exp_z); end
        nresp++;
      end
      adv();
    end
    n_checks++; if (nresp !== 16) begin n_fail++; $display("FAIL bp_count: got %0d responses want 16", nresp); end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin eval(); adv(); end
  endtask

  task automatic test_push_pop();
    pulse_reset();
    req_valid = '1; rsp_ready = 1'b1; rand_x();
    for (int i = 0; i < 2; i++) begin eval(); adv(); end
    eval();
    n_checks++; if ({rsp_valid, busy} !== 2'b11 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL pp_state: got v/b=%b id=%0d want 11/0", {rsp_valid, busy}, rsp_id); end
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL pp_grant: got %b want 0100", req_ready); end
    adv();
    eval();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_z !== exp_z) begin
      n_fail++; $display("FAIL pp_next: got v=%b id=%0d z=%h want 1/1/%h", rsp_valid, rsp_id, rsp_z, exp_z); end
    adv();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      eval();
      n_checks++; if (rsp_valid !== exp_rsp_valid || (exp_rsp_valid && (rsp_id !== IDW'(exp_id) || rsp_z !== exp_z))) begin
        n_fail++; $display("FAIL pp_drain[%0d]: got v=%b id=%0d want %b/%0d", i, rsp_valid, rsp_id, exp_rsp_valid, exp_id); end
      adv();
    end
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    req_valid = '1; rsp_ready = 1'b1; rand_x();
    for (int i = 0; i < 3; i++) begin eval(); adv(); end
    rst = 1'b1;
    eval();
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    adv();
    rst = 1'b0; req_valid = 4'b1010;
    eval();
    n_checks++; if ({rsp_valid, busy} !== 2'b00 || pla_x !== '0) begin
      n_fail++; $display("FAIL mid_flush: got v/b=%b pla_x=%h want 00/0", {rsp_valid, busy}, pla_x); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0010", req_ready); end
    adv();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      eval();
      n_checks++; if (rsp_valid !== exp_rsp_valid || busy !== exp_busy || (exp_rsp_valid && rsp_id !== IDW'(exp_id))) begin
        n_fail++; $display("FAIL mid_after[%0d]: got v=%b b=%b id=%0d want %b/%b/%0d", i, rsp_valid, busy, rsp_id, exp_rsp_valid, exp_busy, exp_id); end
      adv();
    end
  endtask

  task automatic test_golden();
    int nresp;
    pulse_reset();
    nresp = 0;
    for (int i = 0; i < 1004; i++) begin
      if (i < 1000) begin
        req_valid = NREQ'($urandom_range(0, 15));
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      rand_x();
      eval();
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL gold_ready[%0d]: got %b want %b", i, req_ready, exp_ready); end
      n_checks++; if (rsp_valid !== exp_rsp_valid || busy !== exp_busy || pla_x !== m_x) begin
        n_fail++; $display("FAIL gold_ctrl[%0d]: got v=%b b=%b x=%h want %b/%b/%h", i, rsp_valid, busy, pla_x, exp_rsp_valid, exp_busy, m_x); end
      if (exp_rsp_valid) begin
        n_checks++; if (rsp_id !== IDW'(exp_id) || rsp_z !== exp_z) begin
          n_fail++; $display("FAIL gold_rsp[%0d]: got id=%0d z=%h want %0d/%h", i, rsp_id, rsp_z, exp_id, exp_z); end
        if (rsp_ready) nresp++;
      end
      adv();
    end
    n_checks++; if (nresp < 200) begin n_fail++; $display("FAIL gold_volume: got %0d responses want at least 200", nresp); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_push_pop();
    test_reset_midflight();
    test_golden();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
